// File: rtl/ps2_key_encoder_if.sv
// PS/2 receive-side signal bundle: raw pins in, decoded key event word and pulses out.
// The slave modport is the encoder; the master modport is whatever drives the pins.
interface ps2_key_encoder_if;
    logic        ps2_clk;
    logic        ps2_data;
    logic [10:0] ps2_key;
    logic        key_strobe;
    logic        frame_err;

    modport master (
        output ps2_clk,
        output ps2_data,
        input  ps2_key,
        input  key_strobe,
        input  frame_err
    );

    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output ps2_key,
        output key_strobe,
        output frame_err
    );
endinterface

// File: rtl/ps2_key_encoder.sv
// PS/2 scan-code-set-2 receiver producing the 11-bit {toggle, pressed, extended, code} event word.
// Pins are synchronised, ps2_clk is debounced, frames are checked and prefixes folded into the event.
module ps2_key_encoder #(
    parameter int unsigned FILT_LEN = 8,
    parameter int unsigned TIMEOUT  = 48000
) (
    input  logic              clk_sys,
    input  logic              reset,
    ps2_key_encoder_if.slave  ps2_bus
);

    localparam int unsigned    TW       = $clog2(TIMEOUT + 1);
    localparam logic [7:0]     FILT_MAX = 8'(FILT_LEN - 1);
    localparam logic [TW-1:0]  TO_MAX   = TW'(TIMEOUT - 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_EXT     = 3'd1;
    localparam logic [2:0] ST_REL     = 3'd2;
    localparam logic [2:0] ST_EXT_REL = 3'd3;
    localparam logic [2:0] ST_SKIP    = 3'd4;

    logic [1:0]    clk_sync_q, clk_sync_d;
    logic [1:0]    data_sync_q, data_sync_d;
    logic          filt_q, filt_d;
    logic          filt_dly_q, filt_dly_d;
    logic [7:0]    filt_cnt_q, filt_cnt_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [10:0]   shift_q, shift_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          frame_done_q, frame_done_d;
    logic [2:0]    state_q, state_d;
    logic [2:0]    skip_cnt_q, skip_cnt_d;
    logic [10:0]   key_q, key_d;
    logic          strobe_q, strobe_d;
    logic          err_q, err_d;

    logic          fall;
    logic          timeout;
    logic [7:0]    rx_byte;
    logic          frame_ok;
    logic          is_discard;
    logic          ext_flag;
    logic          rel_flag;

    assign fall       = filt_dly_q & ~filt_q;
    assign rx_byte    = shift_q[8:1];
    // Start low, stop high, and data plus parity carry an odd number of ones.
    assign frame_ok   = ~shift_q[0] & shift_q[10] & (^shift_q[9:1]);
    assign is_discard = rx_byte inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};
    assign ext_flag   = (state_q == ST_EXT) || (state_q == ST_EXT_REL);
    assign rel_flag   = (state_q == ST_REL) || (state_q == ST_EXT_REL);

    always_comb begin
        // NOTE: every next-state signal gets a default before any branch, so no latch is inferred.
        clk_sync_d   = {clk_sync_q[0], ps2_bus.ps2_clk};
        data_sync_d  = {data_sync_q[0], ps2_bus.ps2_data};
        filt_d       = filt_q;
        filt_dly_d   = filt_q;
        filt_cnt_d   = '0;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        to_cnt_d     = to_cnt_q;
        frame_done_d = 1'b0;
        timeout      = 1'b0;

        if (clk_sync_q[1] != filt_q) begin
            if (filt_cnt_q == FILT_MAX) begin
                filt_d = clk_sync_q[1];
            end else begin
                filt_cnt_d = filt_cnt_q + 8'd1;
            end
        end

        // A falling edge outranks an expiring timeout in the same cycle.
        if (fall) begin
            shift_d  = {data_sync_q[1], shift_q[10:1]};
            to_cnt_d = '0;
            if (bit_cnt_q == 4'd10) begin
                bit_cnt_d    = '0;
                frame_done_d = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end else if (bit_cnt_q != 4'd0) begin
            if (to_cnt_q == TO_MAX) begin
                timeout   = 1'b1;
                bit_cnt_d = '0;
                to_cnt_d  = '0;
            end else begin
                to_cnt_d = to_cnt_q + TW'(1);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        skip_cnt_d = skip_cnt_q;
        key_d      = key_q;
        strobe_d   = 1'b0;
        err_d      = 1'b0;

        if (timeout) begin
            err_d      = 1'b1;
            state_d    = ST_IDLE;
            skip_cnt_d = '0;
        end else if (frame_done_q) begin
            if (!frame_ok) begin
                err_d      = 1'b1;
                state_d    = ST_IDLE;
                skip_cnt_d = '0;
            end else if (state_q == ST_SKIP) begin
                skip_cnt_d = skip_cnt_q - 3'd1;
                if (skip_cnt_q <= 3'd1) begin
                    state_d = ST_IDLE;
                end
            end else if (is_discard) begin
                state_d = ST_IDLE;
            end else if (rx_byte == 8'hE0) begin
                state_d = rel_flag ? ST_EXT_REL : ST_EXT;
            end else if (rx_byte == 8'hF0) begin
                state_d = ext_flag ? ST_EXT_REL : ST_REL;
            end else if (rx_byte == 8'hE1) begin
                state_d    = ST_SKIP;
                skip_cnt_d = 3'd7;
            end else begin
                key_d    = {~key_q[10], ~rel_flag, ext_flag, rx_byte};
                strobe_d = 1'b1;
                state_d  = ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            // NOTE: pin synchronisers and filter reset to the idle-high level so leaving reset never fakes a falling edge.
            clk_sync_q   <= 2'b11;
            data_sync_q  <= 2'b11;
            filt_q       <= 1'b1;
            filt_dly_q   <= 1'b1;
            filt_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            to_cnt_q     <= '0;
            frame_done_q <= 1'b0;
            state_q      <= ST_IDLE;
            skip_cnt_q   <= '0;
            key_q        <= '0;
            strobe_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            clk_sync_q   <= clk_sync_d;
            data_sync_q  <= data_sync_d;
            filt_q       <= filt_d;
            filt_dly_q   <= filt_dly_d;
            filt_cnt_q   <= filt_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            to_cnt_q     <= to_cnt_d;
            frame_done_q <= frame_done_d;
            state_q      <= state_d;
            skip_cnt_q   <= skip_cnt_d;
            key_q        <= key_d;
            strobe_q     <= strobe_d;
            err_q        <= err_d;
        end
    end

    assign ps2_bus.ps2_key    = key_q;
    assign ps2_bus.key_strobe = strobe_q;
    assign ps2_bus.frame_err  = err_q;

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Bench for ps2_key_encoder: a table of decoded frames, hand-built timing corner cases,
// and random byte streams checked against a flag-level model of the scan-code rules.
module tb_ps2_key_encoder;

    localparam int F    = 8;
    localparam int TO   = 200;
    localparam int HALF = 20;
    localparam int POST = F + 12;

    typedef struct {
        string       name;
        logic [7:0]  code;
        bit          bad;
        bit          exp_strobe;
        bit          exp_err;
        logic [10:0] exp_key;
    } vec_t;

    logic clk_sys = 1'b0;
    logic reset;
    ps2_key_encoder_if bus ();

    ps2_key_encoder #(.FILT_LEN(F), .TIMEOUT(TO)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .ps2_bus (bus)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    int strobe_total = 0;
    int err_total    = 0;
    int both_total   = 0;
    int strobe_cyc   = 0;
    int err_cyc      = 0;
    always @(negedge clk_sys) begin
        if (bus.key_strobe === 1'b1) begin
            strobe_total = strobe_total + 1;
            strobe_cyc   = cyc;
        end
        if (bus.frame_err === 1'b1) begin
            err_total = err_total + 1;
            err_cyc   = cyc;
        end
        if (bus.key_strobe === 1'b1 && bus.frame_err === 1'b1) both_total = both_total + 1;
    end

    int checks = 0;
    int errors = 0;
    int last_fall_cyc = 0;

    logic [10:0] m_key;
    bit          m_ext;
    bit          m_rel;
    int          m_skip;

    task automatic check(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_key  = '0;
        m_ext  = 1'b0;
        m_rel  = 1'b0;
        m_skip = 0;
    endtask

    task automatic model_clear();
        m_ext  = 1'b0;
        m_rel  = 1'b0;
        m_skip = 0;
    endtask

    task automatic model_byte(input logic [7:0] b, input bit bad, output bit exp_strobe, output bit exp_err);
        exp_strobe = 1'b0;
        exp_err    = 1'b0;
        if (bad) begin
            exp_err = 1'b1;
            model_clear();
        end else if (m_skip > 0) begin
            m_skip = m_skip - 1;
        end else if (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF}) begin
            model_clear();
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_rel = 1'b1;
        end else if (b == 8'hE1) begin
            model_clear();
            m_skip = 7;
        end else begin
            m_key      = {~m_key[10], ~m_rel, m_ext, b};
            exp_strobe = 1'b1;
            model_clear();
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    // Drives the first nbits bits of a frame; glitch_bit gets a short low pulse in its high phase.
    task automatic send_bits(input logic [7:0] code, input bit bad, input int nbits, input int glitch_bit);
        logic [10:0] frame;
        frame = {1'b1, (~^code) ^ bad, code, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            bus.ps2_data = frame[i];
            if (i == glitch_bit) begin
                wait_cycles(12);
                bus.ps2_clk = 1'b0;
                wait_cycles(F - 1);
                bus.ps2_clk = 1'b1;
                wait_cycles(12);
            end else begin
                wait_cycles(HALF);
            end
            bus.ps2_clk   = 1'b0;
            last_fall_cyc = cyc;
            wait_cycles(HALF);
            bus.ps2_clk = 1'b1;
        end
        bus.ps2_data = 1'b1;
    endtask

    task automatic run_frame(input string name, input logic [7:0] code, input bit bad, input int glitch_bit,
                             input bit exp_strobe, input bit exp_err, input logic [10:0] exp_key);
        int s0;
        int e0;
        s0 = strobe_total;
        e0 = err_total;
        send_bits(code, bad, 11, glitch_bit);
        wait_cycles(POST);
        check({name, " strobes"}, strobe_total - s0, int'(exp_strobe));
        check({name, " errs"}, err_total - e0, int'(exp_err));
        check({name, " key"}, int'(bus.ps2_key), int'(exp_key));
        if (exp_strobe) check({name, " latency"}, strobe_cyc - last_fall_cyc, F + 4);
    endtask

    vec_t vecs[$];

    initial begin
        bit          ms;
        bit          me;
        int          e0;
        logic [7:0]  code;
        bit          bad;
        logic [7:0]  discards [6];

        discards = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};

        vecs.push_back('{"make 1C",    8'h1C, 1'b0, 1'b1, 1'b0, 11'h61C});
        vecs.push_back('{"pfx E0",     8'hE0, 1'b0, 1'b0, 1'b0, 11'h61C});
        vecs.push_back('{"pfx F0",     8'hF0, 1'b0, 1'b0, 1'b0, 11'h61C});
        vecs.push_back('{"brk E0 75",  8'h75, 1'b0, 1'b1, 1'b0, 11'h175});
        vecs.push_back('{"bad par 29", 8'h29, 1'b1, 1'b0, 1'b1, 11'h175});
        vecs.push_back('{"make 29",    8'h29, 1'b0, 1'b1, 1'b0, 11'h629});
        vecs.push_back('{"pause E1",   8'hE1, 1'b0, 1'b0, 1'b0, 11'h629});
        vecs.push_back('{"pause 14",   8'h14, 1'b0, 1'b0, 1'b0, 11'h629});
        vecs.push_back('{"pause 77",   8'h77, 1'b0, 1'b0, 1'b0, 11'h629});
        vecs.push_back('{"pause E1b",  8'hE1, 1'b0, 1'b0, 1'b0, 11'h629});
        vecs.push_back('{"pause F0",   8'hF0, 1'b0, 1'b0, 1'b0, 11'h629});
        vecs.push_back('{"pause 14b",  8'h14, 1'b0, 1'b0, 1'b0, 11'h629});
        vecs.push_back('{"pause F0b",  8'hF0, 1'b0, 1'b0, 1'b0, 11'h629});
        vecs.push_back('{"pause 77b",  8'h77, 1'b0, 1'b0, 1'b0, 11'h629});
        vecs.push_back('{"make 05",    8'h05, 1'b0, 1'b1, 1'b0, 11'h205});
        vecs.push_back('{"drop AA",    8'hAA, 1'b0, 1'b0, 1'b0, 11'h205});
        vecs.push_back('{"make 1C b",  8'h1C, 1'b0, 1'b1, 1'b0, 11'h61C});
        vecs.push_back('{"pfx F0 b",   8'hF0, 1'b0, 1'b0, 1'b0, 11'h61C});
        vecs.push_back('{"drop AA b",  8'hAA, 1'b0, 1'b0, 1'b0, 11'h61C});
        vecs.push_back('{"make 1C c",  8'h1C, 1'b0, 1'b1, 1'b0, 11'h21C});

        reset        = 1'b1;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        model_reset();
        wait_cycles(4);
        reset = 1'b0;
        wait_cycles(2);
        check("reset key", int'(bus.ps2_key), 0);
        check("reset strobe", int'(bus.key_strobe), 0);
        check("reset err", int'(bus.frame_err), 0);

        foreach (vecs[i]) begin
            run_frame(vecs[i].name, vecs[i].code, vecs[i].bad, -1,
                      vecs[i].exp_strobe, vecs[i].exp_err, vecs[i].exp_key);
            model_byte(vecs[i].code, vecs[i].bad, ms, me);
        end

        // Partial frame then silence: the error lands TO cycles after the last data bit is sampled,
        // which itself happens F+3 cycles after the raw clock edge.
        e0 = err_total;
        send_bits(8'h5A, 1'b0, 5, -1);
        wait_cycles(F + 3 + TO + 10);
        model_clear();
        check("timeout errs", err_total - e0, 1);
        check("timeout latency", err_cyc - last_fall_cyc, F + 3 + TO);
        check("timeout key", int'(bus.ps2_key), int'(m_key));
        model_byte(8'h16, 1'b0, ms, me);
        run_frame("after timeout 16", 8'h16, 1'b0, -1, ms, me, m_key);

        model_byte(8'h1C, 1'b0, ms, me);
        run_frame("glitch 1C", 8'h1C, 1'b0, 4, ms, me, m_key);

        send_bits(8'h33, 1'b0, 5, -1);
        reset = 1'b1;
        wait_cycles(3);
        check("midreset key", int'(bus.ps2_key), 0);
        check("midreset strobe", int'(bus.key_strobe), 0);
        check("midreset err", int'(bus.frame_err), 0);
        reset = 1'b0;
        model_reset();
        wait_cycles(5);
        model_byte(8'h1C, 1'b0, ms, me);
        run_frame("post reset 1C", 8'h1C, 1'b0, -1, ms, me, m_key);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 9))
                0:       code = 8'hE0;
                1:       code = 8'hF0;
                2:       code = 8'hE1;
                3:       code = discards[$urandom_range(0, 5)];
                default: code = 8'($urandom);
            endcase
            bad = ($urandom_range(0, 7) == 0);
            model_byte(code, bad, ms, me);
            run_frame($sformatf("rand%0d %02h", i, code), code, bad, -1, ms, me, m_key);
        end

        check("strobe and err exclusive", both_total, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
